// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite arbiters (write side today, read side later).
package axil_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axil_rr_grant.sv
// Combinational rotating-priority encoder: first requester at or after prio_i, wrapping modulo N.
module axil_rr_grant #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] prio_i,
    output logic [W-1:0] grant_o,
    output logic         valid_o
);

    logic [31:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = 32'(prio_i) + 32'(unsigned'(k));
            if (idx >= 32'(unsigned'(N))) begin
                idx = idx - 32'(unsigned'(N));
            end
            if (!valid_o && req_i[idx[W-1:0]]) begin
                valid_o = 1'b1;
                grant_o = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/axil_wr_arbiter.sv
// Round-robin AXI4-Lite write arbiter, one AW+W+B transaction in flight.
// Define AXIL_WR_ARB_FIXED_PRIO_EN to pin priority to port 0 (lowest index always wins).
//
// state | meaning
// IDLE  | no grant; pick next requester from awvalid
// ADDR  | granted port's AW and W routed to master until both handshake
// RESP  | waiting for the B handshake, routed to the granted port only
module axil_wr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int S_COUNT    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [S_COUNT*3-1:0]          s_axil_awprot,
    input  logic [S_COUNT-1:0]            s_axil_awvalid,
    output logic [S_COUNT-1:0]            s_axil_awready,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [S_COUNT*STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic [S_COUNT-1:0]            s_axil_wvalid,
    output logic [S_COUNT-1:0]            s_axil_wready,
    output logic [S_COUNT*2-1:0]          s_axil_bresp,
    output logic [S_COUNT-1:0]            s_axil_bvalid,
    input  logic [S_COUNT-1:0]            s_axil_bready,
    output logic [ADDR_WIDTH-1:0]         m_axil_awaddr,
    output logic [2:0]                    m_axil_awprot,
    output logic                          m_axil_awvalid,
    input  logic                          m_axil_awready,
    output logic [DATA_WIDTH-1:0]         m_axil_wdata,
    output logic [STRB_WIDTH-1:0]         m_axil_wstrb,
    output logic                          m_axil_wvalid,
    input  logic                          m_axil_wready,
    input  logic [1:0]                    m_axil_bresp,
    input  logic                          m_axil_bvalid,
    output logic                          m_axil_bready
);

    localparam int IDX_W = idx_width(S_COUNT);

    arb_state_t       state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] prio_q;
    logic [IDX_W-1:0] prio_d;
    logic             aw_done_q;
    logic             w_done_q;

    logic [IDX_W-1:0] rr_grant;
    logic             rr_valid;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;

    axil_rr_grant #(
        .N (S_COUNT),
        .W (IDX_W)
    ) u_rr_grant (
        .req_i   (s_axil_awvalid),
        .prio_i  (prio_q),
        .grant_o (rr_grant),
        .valid_o (rr_valid)
    );

`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
    assign prio_d = '0;
`else
    assign prio_d = (grant_q == IDX_W'(S_COUNT - 1)) ? '0 : grant_q + 1'b1;
`endif

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;
    assign b_hs  = m_axil_bvalid & m_axil_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            prio_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_valid) begin
                        grant_q <= rr_grant;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    // AW and W may complete in either order or together
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        prio_q    <= prio_d;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_axil_awaddr  = '0;
        m_axil_awprot  = '0;
        m_axil_awvalid = 1'b0;
        m_axil_wdata   = '0;
        m_axil_wstrb   = '0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        s_axil_awready = '0;
        s_axil_wready  = '0;
        s_axil_bvalid  = '0;
        s_axil_bresp   = '0;
        if (state_q == ADDR) begin
            m_axil_awaddr           = s_axil_awaddr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            m_axil_awprot           = s_axil_awprot[grant_q*3 +: 3];
            m_axil_wdata            = s_axil_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
            m_axil_wstrb            = s_axil_wstrb[grant_q*STRB_WIDTH +: STRB_WIDTH];
            m_axil_awvalid          = s_axil_awvalid[grant_q] & ~aw_done_q;
            m_axil_wvalid           = s_axil_wvalid[grant_q] & ~w_done_q;
            s_axil_awready[grant_q] = m_axil_awready & ~aw_done_q;
            s_axil_wready[grant_q]  = m_axil_wready & ~w_done_q;
        end
        if (state_q == RESP) begin
            m_axil_bready          = s_axil_bready[grant_q];
            s_axil_bvalid[grant_q] = m_axil_bvalid;
            s_axil_bresp           = {S_COUNT{m_axil_bresp}};
        end
    end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Randomized bench for axil_wr_arbiter with a transaction-level round-robin reference model.
module tb_axil_wr_arbiter;
    import axil_arb_pkg::*;

    localparam int S  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [S*AW-1:0] s_axil_awaddr;
    logic [S*3-1:0]  s_axil_awprot;
    logic [S-1:0]    s_axil_awvalid;
    logic [S-1:0]    s_axil_awready;
    logic [S*DW-1:0] s_axil_wdata;
    logic [S*SW-1:0] s_axil_wstrb;
    logic [S-1:0]    s_axil_wvalid;
    logic [S-1:0]    s_axil_wready;
    logic [S*2-1:0]  s_axil_bresp;
    logic [S-1:0]    s_axil_bvalid;
    logic [S-1:0]    s_axil_bready;
    logic [AW-1:0]   m_axil_awaddr;
    logic [2:0]      m_axil_awprot;
    logic            m_axil_awvalid;
    logic            m_axil_awready;
    logic [DW-1:0]   m_axil_wdata;
    logic [SW-1:0]   m_axil_wstrb;
    logic            m_axil_wvalid;
    logic            m_axil_wready;
    logic [1:0]      m_axil_bresp;
    logic            m_axil_bvalid;
    logic            m_axil_bready;

    axil_wr_arbiter #(
        .S_COUNT    (S),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awprot  (m_axil_awprot),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    int errors = 0;
    int checks = 0;

    // traffic knobs
    int req_pct = 0, awr_pct = 100, wr_pct = 100, bv_pct = 100, brdy_pct = 100;
    int spur_pct = 0, max_dly = 0, force_resp = 0;

    // requesters
    logic [AW-1:0] rq_addr[S];
    logic [DW-1:0] rq_data[S];
    logic [SW-1:0] rq_strb[S];
    logic [2:0]    rq_prot[S];
    logic [1:0]    rq_resp[S];
    int            rq_awd[S], rq_wd[S], rq_left[S], rq_done[S];
    bit            rq_busy[S], rq_awp[S], rq_wp[S];

    // downstream slave
    bit         sl_aw, sl_w, sl_bv;
    logic [1:0] sl_resp;

    // reference model: who owns the master port and what has completed
    bit m_free, m_new, m_aws, m_ws;
    int m_prio, m_port;
    int n_aw_hs, n_w_hs, n_b_hs, n_started;
    int grant_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic start_txn(input int p, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st, input logic [2:0] pr, input int awd, input int wd);
        rq_addr[p] = a;
        rq_data[p] = d;
        rq_strb[p] = st;
        rq_prot[p] = pr;
        rq_awd[p]  = awd;
        rq_wd[p]   = wd;
        rq_busy[p] = 1'b1;
        rq_awp[p]  = 1'b1;
        rq_wp[p]   = 1'b1;
        n_started++;
    endtask

    function automatic logic [1:0] pick_resp();
        int r;
        if (force_resp >= 0) return 2'(force_resp);
        r = $urandom_range(0, 2);
        return (r == 0) ? RESP_OKAY : (r == 1) ? RESP_SLVERR : RESP_DECERR;
    endfunction

    function automatic bit all_idle();
        for (int p = 0; p < S; p++) begin
            if (rq_busy[p] || rq_left[p] > 0) return 1'b0;
        end
        return m_free && !sl_bv && !sl_aw && !sl_w;
    endfunction

    task automatic cycle();
        logic [S-1:0] gm;
        bit aw_hs, w_hs, b_hs;
        @(negedge clk);
        for (int p = 0; p < S; p++) begin
            if (!rq_busy[p] && rq_left[p] > 0 && $urandom_range(0, 99) < req_pct) begin
                start_txn(p, {4'(p), 28'($urandom)}, $urandom, 4'($urandom_range(1, 15)),
                          3'($urandom), $urandom_range(0, max_dly), $urandom_range(0, max_dly));
                rq_left[p]--;
            end
            s_axil_awaddr[p*AW +: AW] = rq_addr[p];
            s_axil_awprot[p*3 +: 3]   = rq_prot[p];
            s_axil_wdata[p*DW +: DW]  = rq_data[p];
            s_axil_wstrb[p*SW +: SW]  = rq_strb[p];
            s_axil_awvalid[p] = rq_awp[p] && rq_awd[p] == 0;
            s_axil_wvalid[p]  = rq_wp[p] && rq_wd[p] == 0;
            if (rq_awd[p] > 0) rq_awd[p]--;
            if (rq_wd[p] > 0) rq_wd[p]--;
            s_axil_bready[p] = $urandom_range(0, 99) < brdy_pct;
        end
        m_axil_awready = $urandom_range(0, 99) < awr_pct;
        m_axil_wready  = $urandom_range(0, 99) < wr_pct;
        if (!sl_bv && sl_aw && sl_w && $urandom_range(0, 99) < bv_pct) begin
            sl_bv   = 1'b1;
            sl_resp = pick_resp();
        end
        m_axil_bvalid = sl_bv;
        m_axil_bresp  = sl_bv ? sl_resp : 2'($urandom);
        // a misbehaving slave pulsing bvalid before the write is complete
        if (!sl_bv && !(sl_aw && sl_w) && $urandom_range(0, 99) < spur_pct) m_axil_bvalid = 1'b1;
        #1;
        gm = m_free ? '0 : (S'(1) << m_port);
        check("stray_awready", s_axil_awready & ~gm, '0);
        check("stray_wready", s_axil_wready & ~gm, '0);
        check("stray_bvalid", s_axil_bvalid & ~gm, '0);
        if (m_new) check("grant_latency", m_axil_awvalid, 1'b1);
        m_new = 1'b0;
        if (m_free) begin
            check("idle_outputs", {m_axil_awvalid, m_axil_wvalid, m_axil_bready}, '0);
        end else begin
            if (m_axil_awvalid)
                check("aw_payload", {m_axil_awprot, m_axil_awaddr}, {rq_prot[m_port], rq_addr[m_port]});
            if (m_axil_wvalid)
                check("w_payload", {m_axil_wstrb, m_axil_wdata}, {rq_strb[m_port], rq_data[m_port]});
            if (m_aws) check("aw_dropped", m_axil_awvalid, 1'b0);
            if (m_ws) check("w_dropped", m_axil_wvalid, 1'b0);
            if (m_aws && m_ws) check("resp_bready", m_axil_bready, s_axil_bready[m_port]);
            else check("addr_bready", m_axil_bready, 1'b0);
        end
        aw_hs = m_axil_awvalid && m_axil_awready;
        w_hs  = m_axil_wvalid && m_axil_wready;
        b_hs  = m_axil_bvalid && m_axil_bready;
        if (b_hs) begin
            check("b_after_aw_w", {m_aws, m_ws, sl_bv}, 3'b111);
            check("b_route", s_axil_bvalid, gm);
            check("bresp_pass", s_axil_bresp[m_port*2 +: 2], m_axil_bresp);
            n_b_hs++;
        end
        if (aw_hs) begin
            check("aw_once", m_aws, 1'b0);
            m_aws = 1'b1;
            n_aw_hs++;
            grant_log.push_back(int'(m_axil_awaddr[AW-1:AW-4]));
        end
        if (w_hs) begin
            check("w_once", m_ws, 1'b0);
            m_ws = 1'b1;
            n_w_hs++;
        end
        for (int p = 0; p < S; p++) begin
            if (s_axil_awvalid[p] && s_axil_awready[p]) rq_awp[p] = 1'b0;
            if (s_axil_wvalid[p] && s_axil_wready[p]) rq_wp[p] = 1'b0;
            if (s_axil_bvalid[p] && s_axil_bready[p]) begin
                rq_resp[p] = s_axil_bresp[p*2 +: 2];
                rq_busy[p] = 1'b0;
                rq_done[p]++;
            end
        end
        if (aw_hs) sl_aw = 1'b1;
        if (w_hs) sl_w = 1'b1;
        if (b_hs) begin
            sl_bv = 1'b0;
            sl_aw = 1'b0;
            sl_w  = 1'b0;
        end
        if (m_free) begin
            for (int k = 0; k < S; k++) begin
                if (m_free && s_axil_awvalid[(m_prio + k) % S]) begin
                    m_port = (m_prio + k) % S;
                    m_free = 1'b0;
                    m_new  = 1'b1;
                    m_aws  = 1'b0;
                    m_ws   = 1'b0;
                end
            end
        end else if (b_hs) begin
            m_free = 1'b1;
`ifndef AXIL_WR_ARB_FIXED_PRIO_EN
            m_prio = (m_port + 1) % S;
`endif
        end
    endtask

    task automatic run(input string tag, input int maxc);
        int c = 0;
        while (!all_idle() && c < maxc) begin
            cycle();
            c++;
        end
        check({tag, "_finished"}, all_idle(), 1'b1);
        check({tag, "_aw_count"}, n_aw_hs, n_started);
        check({tag, "_w_count"}, n_w_hs, n_started);
        check({tag, "_b_count"}, n_b_hs, n_started);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_axil_awvalid = '0;
        s_axil_wvalid  = '0;
        s_axil_bready  = '0;
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b0;
        for (int p = 0; p < S; p++) begin
            rq_busy[p] = 1'b0; rq_awp[p] = 1'b0; rq_wp[p] = 1'b0;
            rq_left[p] = 0; rq_done[p] = 0; rq_awd[p] = 0; rq_wd[p] = 0;
            rq_resp[p] = 2'b01;
        end
        sl_aw = 1'b0; sl_w = 1'b0; sl_bv = 1'b0;
        m_free = 1'b1; m_new = 1'b0; m_aws = 1'b0; m_ws = 1'b0; m_prio = 0; m_port = 0;
        n_aw_hs = 0; n_w_hs = 0; n_b_hs = 0; n_started = 0;
        @(negedge clk);
        check("rst_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_bready,
                             s_axil_awready, s_axil_wready, s_axil_bvalid}, '0);
        check("rst_payload", {m_axil_awprot, m_axil_awaddr, m_axil_wstrb, m_axil_wdata}, '0);
        check("rst_bresp", s_axil_bresp, '0);
        rst = 1'b0;
    endtask

    function automatic int fair_exp(input int i);
`ifdef AXIL_WR_ARB_FIXED_PRIO_EN
        return (i < 4) ? 0 : 1;
`else
        return i % 2;
`endif
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        s_axil_awaddr = '1; s_axil_awprot = '1; s_axil_wdata = '1; s_axil_wstrb = '1;
        m_axil_bresp = 2'b11;
        for (int p = 0; p < S; p++) begin
            rq_addr[p] = '1; rq_data[p] = '1; rq_strb[p] = '1; rq_prot[p] = '1;
        end
        do_reset();

        // single request on port 1
        start_txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0);
        run("single", 50);
        check("single_resp", rq_resp[1], RESP_OKAY);
        check("single_p0_untouched", rq_done[0], 0);

        // fairness between two always-busy requesters
        grant_log.delete();
        rq_left[0] = 4;
        rq_left[1] = 4;
        req_pct    = 100;
        run("fair", 200);
        check("fair_len", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) check("fair_order", grant_log[i], fair_exp(i));
        req_pct = 0;

        // W presented three cycles ahead of AW
        start_txn(0, 32'h0000_0040, 32'h1234_5678, 4'h3, 3'b010, 3, 0);
        run("w_first", 50);

        // master-side backpressure with toggling bready
        start_txn(2, 32'h2000_0080, 32'hCAFE_F00D, 4'hC, 3'b101, 0, 0);
        awr_pct = 0; wr_pct = 0; brdy_pct = 50;
        repeat (5) cycle();
        awr_pct = 100;
        repeat (4) cycle();
        wr_pct = 100;
        run("backpressure", 100);
        brdy_pct = 100;

        // SLVERR pass-through, then a normal transaction
        force_resp = 2;
        start_txn(1, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 0);
        run("slverr", 50);
        check("slverr_resp", rq_resp[1], RESP_SLVERR);
        force_resp = 0;
        start_txn(0, 32'h0000_0008, 32'h5A5A_5A5A, 4'hF, 3'b000, 0, 0);
        run("after_slverr", 50);
        check("after_slverr_resp", rq_resp[0], RESP_OKAY);

        // randomized traffic, all ports, misbehaving slave bvalid
        req_pct = 35; awr_pct = 55; wr_pct = 55; bv_pct = 50; brdy_pct = 60;
        spur_pct = 10; max_dly = 3; force_resp = -1;
        for (int p = 0; p < S; p++) rq_left[p] = 30;
        run("random", 20000);
        check("random_done_sum", rq_done[0] + rq_done[1] + rq_done[2], n_started);

        // reset after AW but before W
        req_pct = 0; awr_pct = 100; wr_pct = 0; bv_pct = 100; brdy_pct = 100;
        spur_pct = 0; max_dly = 0; force_resp = 0;
        do_reset();
        start_txn(1, 32'h1000_0100, 32'h0BAD_F00D, 4'hF, 3'b000, 0, 0);
        for (int i = 0; i < 20 && n_aw_hs == 0; i++) cycle();
        check("midaddr_aw_seen", n_aw_hs, 1);
        do_reset();
        wr_pct = 100;
        start_txn(1, 32'h1000_0200, 32'h600D_600D, 4'hF, 3'b000, 0, 0);
        run("post_reset", 50);
        check("post_reset_resp", rq_resp[1], RESP_OKAY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
